sync_fifo: RTL and testbench

- Single-clock FIFO: data buffer plus status flags (full, almost-full, empty, almost-empty).
- Keeps the same write/read handshake, flag semantics and first-word-fall-through option as the team's dual-clock FIFO.
- Used between two blocks in the same clock domain. No CDC logic.

---
 rtl/sync_fifo_pkg.sv | 24 ++
 rtl/sync_fifo_ram.sv | 25 ++
 rtl/sync_fifo.sv | 129 ++++++++++++
 tb/tb_sync_fifo.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the single-clock FIFO: depth helper, count type and
// decoding of the FALLTHROUGH parameter into a read-mode enum.
package sync_fifo_pkg;

    typedef enum logic {
        FT_REGISTERED = 1'b0,
        FT_COMB       = 1'b1
    } ft_mode_e;

    localparam int unsigned ASIZE_DEFAULT = 4;

    // Occupancy for the default geometry; 0..DEPTH needs one bit more than a pointer.
    typedef logic [ASIZE_DEFAULT:0] count_t;

    function automatic int unsigned depth_of(input int unsigned asize);
        return 32'd1 << asize;
    endfunction

    // Only the exact string "TRUE" selects fall-through; anything else is registered.
    function automatic ft_mode_e ft_mode_of(input logic [39:0] ft);
        return (ft == 40'("TRUE")) ? FT_COMB : FT_REGISTERED;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// DEPTH x DSIZE storage for sync_fifo: one synchronous write port and one
// combinational read port. Contents are never reset.
module sync_fifo_ram #(
    parameter int unsigned DSIZE = 32,
    parameter int unsigned ASIZE = 4
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [ASIZE-1:0] i_waddr,
    input  logic [DSIZE-1:0] i_wdata,
    input  logic [ASIZE-1:0] i_raddr,
    output logic [DSIZE-1:0] o_rdata
);

    logic [DSIZE-1:0] r_mem [2**ASIZE];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/almost-full/empty/almost-empty flags and an
// optional fall-through read. Define SYNC_FIFO_ERR_FLAGS_EN for sticky overflow/underflow.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DSIZE      = 32,
    parameter int unsigned ASIZE      = 4,
    parameter              FALLTHROUGH = "TRUE",
    parameter int unsigned AWFULL_TH  = 1,
    parameter int unsigned AREMPTY_TH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    output logic             wfull,
    output logic             awfull,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rempty,
    output logic             arempty
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    output logic             overflow,
    output logic             underflow
`endif
);

    localparam int unsigned DEPTH   = depth_of(ASIZE);
    localparam ft_mode_e    FT_MODE = ft_mode_of(40'(FALLTHROUGH));

    typedef logic [ASIZE:0] cnt_t;

    localparam cnt_t CNT_FULL  = cnt_t'(DEPTH);
    localparam cnt_t CNT_AF_LO = cnt_t'(DEPTH - AWFULL_TH);
    localparam cnt_t CNT_AE_HI = cnt_t'(AREMPTY_TH);

    // Handshake: winc/rinc are requests; a write is taken on an edge only while
    // !wfull and a read only while !rempty. Refused requests are simply dropped.
    logic             w_wr_en;
    logic             w_rd_en;
    logic [DSIZE-1:0] w_ram_rdata;

    logic [ASIZE-1:0] r_wptr;
    logic [ASIZE-1:0] r_rptr;
    cnt_t             r_count;

    assign w_wr_en = winc && !wfull;
    assign w_rd_en = rinc && !rempty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr_en) begin
                r_wptr <= r_wptr + ASIZE'(1);
            end
            if (w_rd_en) begin
                r_rptr <= r_rptr + ASIZE'(1);
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + cnt_t'(1);
                2'b01:   r_count <= r_count - cnt_t'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Flags come straight from the registered count, so they describe the state after the last edge.
    assign wfull   = (r_count == CNT_FULL);
    assign rempty  = (r_count == '0);
    assign awfull  = (r_count >= CNT_AF_LO) && (r_count != CNT_FULL);
    assign arempty = (r_count != '0) && (r_count <= CNT_AE_HI);

    sync_fifo_ram #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) u_ram (
        .i_clk   (clk),
        .i_we    (w_wr_en),
        .i_waddr (r_wptr),
        .i_wdata (wdata),
        .i_raddr (r_rptr),
        .o_rdata (w_ram_rdata)
    );

    generate
        if (FT_MODE == FT_COMB) begin : g_fallthrough
            assign rdata = w_ram_rdata;
        end else begin : g_registered
            logic [DSIZE-1:0] r_rdata;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rdata <= '0;
                end else if (w_rd_en) begin
                    r_rdata <= w_ram_rdata;
                end
            end

            assign rdata = r_rdata;
        end
    endgenerate

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (winc && wfull) begin
                r_overflow <= 1'b1;
            end
            if (rinc && rempty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo (DSIZE=32, ASIZE=4, fall-through, margins of 1): driver
// tasks push accepted writes into exp_q; a negedge monitor checks flags and popped data.
module tb_sync_fifo;

    logic        clk;
    logic        rst;
    logic        winc;
    logic [31:0] wdata;
    logic        wfull;
    logic        awfull;
    logic        rinc;
    logic [31:0] rdata;
    logic        rempty;
    logic        arempty;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic        overflow;
    logic        underflow;
`endif

    logic [31:0] exp_q[$];
    int          m_count;
    bit          armed;
    int          n_checks;
    int          n_errors;
    logic [31:0] next_data;

    sync_fifo #(
        .DSIZE      (32),
        .ASIZE      (4),
        .FALLTHROUGH("TRUE"),
        .AWFULL_TH  (1),
        .AREMPTY_TH (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .winc    (winc),
        .wdata   (wdata),
        .wfull   (wfull),
        .awfull  (awfull),
        .rinc    (rinc),
        .rdata   (rdata),
        .rempty  (rempty),
        .arempty (arempty)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        ,
        .overflow  (overflow),
        .underflow (underflow)
`endif
    );

    // Clock and reset-time defaults
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model decides acceptance from its own count.
    task automatic tick(input logic w, input logic [31:0] d, input logic r, input logic rs);
        bit wr_ok;
        bit rd_ok;
        winc  = w;
        wdata = d;
        rinc  = r;
        rst   = rs;
        wr_ok = w && (m_count != 16);
        rd_ok = r && (m_count != 0);
        @(posedge clk);
        if (rs) begin
            exp_q.delete();
            m_count = 0;
        end else begin
            if (rd_ok) void'(exp_q.pop_front());
            if (wr_ok) exp_q.push_back(d);
            m_count = m_count + (wr_ok ? 1 : 0) - (rd_ok ? 1 : 0);
        end
        #1;
    endtask

    task automatic write_word(input logic [31:0] d);
        tick(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic read_word();
        tick(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    // Monitor: flags every cycle, data whenever a pop is presented.
    always @(negedge clk) begin
        if (armed && !rst) begin
            check("flags{wfull,awfull,rempty,arempty}", {28'h0, wfull, awfull, rempty, arempty},
                  {28'h0, m_count == 16, m_count == 15, m_count == 0, m_count == 1});
            if (rinc && m_count != 0 && exp_q.size() != 0) begin
                check("rdata", rdata, exp_q[0]);
            end
        end
    end

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        m_count   = 0;
        armed     = 1'b0;
        next_data = 32'h0;
        winc      = 1'b0;
        rinc      = 1'b0;
        wdata     = 32'h0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        tick(1'b0, 32'h0, 1'b0, 1'b1);
        armed = 1'b1;

        // Idle after reset
        tick(1'b0, 32'h0, 1'b0, 1'b0);
        check("reset_flags", {28'h0, wfull, awfull, rempty, arempty}, 32'h2);

        // Single word, fall-through visible one edge after the write
        write_word(32'hA);
        check("single_rdata", rdata, 32'hA);
        check("single_rempty", {31'h0, rempty}, 32'h0);
        read_word();
        check("single_empty_after_pop", {31'h0, rempty}, 32'h1);

        // Burst of 0..9 then ten reads
        for (int i = 0; i < 10; i++) write_word(32'(i));
        for (int i = 0; i < 10; i++) read_word();
        check("burst_empty", {31'h0, rempty}, 32'h1);

        // Thresholds: 1, 15, 16 and a refused 17th write
        write_word(32'h0);
        check("one_word_flags", {28'h0, wfull, awfull, rempty, arempty}, 32'h1);
        for (int i = 1; i < 15; i++) write_word(32'(i));
        check("fifteen_flags", {28'h0, wfull, awfull, rempty, arempty}, 32'h4);
        write_word(32'hF);
        check("sixteen_flags", {28'h0, wfull, awfull, rempty, arempty}, 32'h8);
        write_word(32'h99);
        check("overfill_flags", {28'h0, wfull, awfull, rempty, arempty}, 32'h8);
        check("overfill_head", rdata, 32'h0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        check("overflow_set", {31'h0, overflow}, 32'h1);
`endif
        // Full with both requests: only the read is taken
        tick(1'b1, 32'h55, 1'b1, 1'b0);
        check("full_rw_flags", {28'h0, wfull, awfull, rempty, arempty}, 32'h4);
        check("full_rw_head", rdata, 32'h1);
        for (int i = 0; i < 15; i++) read_word();
        check("drained", {31'h0, rempty}, 32'h1);

        // Random concurrent traffic
        next_data = 32'h100;
        for (int i = 0; i < 80; i++) begin
            tick(1'($urandom_range(0, 1)), next_data, 1'($urandom_range(0, 1)), 1'b0);
            next_data++;
        end
        while (m_count != 0) read_word();

        // Pointer wrap: 40 words streamed through a shallow backlog
        for (int i = 0; i < 3; i++) begin
            write_word(next_data);
            next_data++;
        end
        for (int i = 0; i < 40; i++) begin
            tick(1'b1, next_data, 1'b1, 1'b0);
            next_data++;
        end
        for (int i = 0; i < 3; i++) read_word();
        check("wrap_empty", {31'h0, rempty}, 32'h1);

        // Reset with five words held, requests during reset ignored
        for (int i = 0; i < 5; i++) write_word(32'h200 + 32'(i));
        tick(1'b1, 32'h300, 1'b1, 1'b1);
        check("mid_reset_flags", {28'h0, wfull, awfull, rempty, arempty}, 32'h2);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        check("overflow_cleared", {31'h0, overflow}, 32'h0);
`endif
        write_word(32'h77);
        check("post_reset_rdata", rdata, 32'h77);
        read_word();
        check("post_reset_empty", {31'h0, rempty}, 32'h1);

        tick(1'b0, 32'h0, 1'b0, 1'b0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
